// File: rtl/apb_mem_controller.sv
// rtl/apb_mem_controller.sv - Load/store sequencer running one APB transfer per CPU memory request
module apb_mem_controller #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;
  logic       fail_q;
  logic       req;
  logic       timeout_hit;

  assign req         = mem_read | mem_write;
  assign timeout_hit = (state == ACCESS) && !pready && (wait_cnt == TIMEOUT_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // APB control and stall decode straight from state, so an async reset drops psel at once
  always_comb begin
    state_nxt = state;
    psel      = 1'b0;
    penable   = 1'b0;
    stall     = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        stall = req;
        if (req) begin
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        psel      = 1'b1;
        stall     = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        stall   = 1'b1;
        if (pready || timeout_hit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        err       = fail_q;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // fail_q collects illegal-request, slave-error and timeout causes for the DONE cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      paddr    <= '0;
      pwdata   <= '0;
      pwrite   <= 1'b0;
      rdata    <= '0;
      wait_cnt <= '0;
      fail_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            paddr    <= addr;
            pwdata   <= wdata;
            pwrite   <= mem_write;
            fail_q   <= mem_read & mem_write;
            wait_cnt <= '0;
          end
        end
        ACCESS: begin
          if (pready) begin
            if (!pwrite) begin
              rdata <= pslverr ? '0 : prdata;
            end
            fail_q <= fail_q | pslverr;
          end else if (timeout_hit) begin
            if (!pwrite) begin
              rdata <= '0;
            end
            fail_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_mem_controller.sv
// tb/tb_apb_mem_controller.sv - Scoreboard bench for apb_mem_controller with a scripted APB completer
module tb_apb_mem_controller;

  localparam int TO = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic        stall;
  logic        err;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [15:0] paddr;
  logic [15:0] pwdata;
  logic [15:0] prdata = '0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;

  apb_mem_controller #(
    .ADDR_W (16),
    .DATA_W (16),
    .TIMEOUT(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .stall    (stall),
    .err      (err),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .pready   (pready),
    .pslverr  (pslverr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          waits;
    logic [15:0] prd;
    logic        serr;
    int          gap;
    logic [15:0] exp_rdata;
    logic        exp_err;
    int          exp_stall;
  } vec_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        pwrite;
    logic [15:0] rdata;
    logic        err;
    int          stall;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[10];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int setups = 0;
  int stall_cycles = 0;

  int          cfg_waits = 0;
  logic [15:0] cfg_prd = '0;
  logic        cfg_serr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: actual %0h expected %0h", name, act, expv);
    end
  endtask

  // Completer: garbage on prdata/pslverr while not ready, real response on the scripted ACCESS cycle
  initial begin
    int acc_k;
    acc_k = 0;
    forever begin
      @(negedge clk);
      if (psel && penable) begin
        pready = (acc_k == cfg_waits);
        prdata = pready ? cfg_prd : 16'hDEAD;
        pslverr = pready ? cfg_serr : 1'b1;
        acc_k++;
      end else begin
        acc_k = 0;
        pready = 1'b0;
        prdata = 16'h0000;
        pslverr = 1'b0;
      end
    end
  end

  // Monitor: per-cycle APB checks against the queue head, full compare on the DONE cycle
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stall_cycles = 0;
    end else begin
      if (psel && !penable) setups++;
      if ((mem_read || mem_write) && !stall) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: actual response expected none");
        end else begin
          e = exp_q.pop_front();
          chk("rdata", 32'(rdata), 32'(e.rdata));
          chk("err", 32'(err), 32'(e.err));
          chk("stall_len", 32'(stall_cycles), 32'(e.stall));
          chk("done_psel", {psel, penable}, 32'h0);
        end
        stall_cycles = 0;
      end else begin
        chk("err_quiet", 32'(err), 32'h0);
        if ((mem_read || mem_write) && stall) begin
          if (exp_q.size() > 0) begin
            e = exp_q[0];
            chk("psel_seq", 32'(psel), 32'(stall_cycles >= 1));
            chk("penable_seq", 32'(penable), 32'(stall_cycles >= 2));
            if (penable) begin
              chk("paddr", 32'(paddr), 32'(e.addr));
              chk("pwrite", 32'(pwrite), 32'(e.pwrite));
              if (e.pwrite) chk("pwdata", 32'(pwdata), 32'(e.wdata));
            end
          end
          stall_cycles++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int start;
    bit seen;
    //             rd    wr    addr     wdata    waits prd      serr gap exp_rdata exp_err stall
    vecs[0] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 0,   16'hBEEF, 1'b0, 1, 16'hBEEF, 1'b0, 3};
    vecs[1] = '{1'b0, 1'b1, 16'h0010, 16'h1234, 2,   16'h0000, 1'b0, 0, 16'hBEEF, 1'b0, 5};
    vecs[2] = '{1'b1, 1'b0, 16'h0022, 16'h0000, 0,   16'h5555, 1'b1, 2, 16'h0000, 1'b1, 3};
    vecs[3] = '{1'b1, 1'b0, 16'h0030, 16'h0000, 1,   16'hA5A5, 1'b0, 0, 16'hA5A5, 1'b0, 4};
    vecs[4] = '{1'b1, 1'b0, 16'h0044, 16'h0000, 255, 16'h7777, 1'b0, 0, 16'h0000, 1'b1, 6};
    vecs[5] = '{1'b1, 1'b0, 16'h0046, 16'h0000, 0,   16'h1357, 1'b0, 1, 16'h1357, 1'b0, 3};
    vecs[6] = '{1'b1, 1'b1, 16'h0050, 16'h00FF, 0,   16'h9999, 1'b0, 0, 16'h1357, 1'b1, 3};
    vecs[7] = '{1'b1, 1'b0, 16'h0060, 16'h0000, 0,   16'h2468, 1'b0, 0, 16'h2468, 1'b0, 3};
    vecs[8] = '{1'b0, 1'b1, 16'h0070, 16'hCAFE, 255, 16'h0000, 1'b0, 1, 16'h2468, 1'b1, 6};
    vecs[9] = '{1'b0, 1'b1, 16'h0080, 16'h4321, 3,   16'h0000, 1'b0, 0, 16'h2468, 1'b0, 6};

    @(negedge clk);
    #1;
    chk("rst_psel", 32'(psel), 32'h0);
    chk("rst_penable", 32'(penable), 32'h0);
    chk("rst_pwrite", 32'(pwrite), 32'h0);
    chk("rst_paddr", 32'(paddr), 32'h0);
    chk("rst_pwdata", 32'(pwdata), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    mem_read = 1'b1;
    #1;
    chk("rst_stall_comb", 32'(stall), 32'h1);
    mem_read = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int v = 0; v < 10; v++) begin
      if (vecs[v].gap > 0) begin
        mem_read = 1'b0;
        mem_write = 1'b0;
        repeat (vecs[v].gap) @(posedge clk);
        #1;
      end
      cfg_waits = vecs[v].waits;
      cfg_prd = vecs[v].prd;
      cfg_serr = vecs[v].serr;
      e.addr = vecs[v].addr;
      e.wdata = vecs[v].wdata;
      e.pwrite = vecs[v].wr;
      e.rdata = vecs[v].exp_rdata;
      e.err = vecs[v].exp_err;
      e.stall = vecs[v].exp_stall;
      exp_q.push_back(e);
      addr = vecs[v].addr;
      wdata = vecs[v].wdata;
      mem_read = vecs[v].rd;
      mem_write = vecs[v].wr;
      start = done_cnt;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(posedge clk);
        if (done_cnt != start) begin
          seen = 1'b1;
          break;
        end
      end
      #1;
      if (!seen) begin
        checks++;
        errors++;
        $display("FAIL done_timeout: actual no DONE expected DONE for vector %0d", v);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
    mem_read = 1'b0;
    mem_write = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset during a stuck ACCESS after a successful read left rdata non-zero
    cfg_waits = 255;
    addr = 16'h0090;
    mem_read = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (penable) begin
        seen = 1'b1;
        break;
      end
    end
    chk("reach_access", 32'(seen), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_psel", 32'(psel), 32'h0);
    chk("midrst_penable", 32'(penable), 32'h0);
    chk("midrst_rdata", 32'(rdata), 32'h0);
    chk("midrst_err", 32'(err), 32'h0);
    mem_read = 1'b0;
    #1;
    chk("midrst_idle", 32'(stall), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("setup_count", 32'(setups), 32'd11);
    chk("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
